ps_bram_result_writer: RTL

Write-back path from the accelerator to the PS: it accepts 256-bit result words, such as the Conv1_1 `test_data` / `test_data_write_enable` stream, and buffers them in a small FIFO. Each buffered word is serialized into four 64-bit beats and written into the PS-side BRAM at consecutive addresses. Writes pause while the PS holds `PS_BRAM_busy`, and the block signals frame completion to the PS.

---
 rtl/ps_bram_result_writer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ps_bram_result_writer.sv
// ps_bram_result_writer: buffers 256-bit result words and
// writes them to the PS BRAM as four 64-bit beats each.
module ps_bram_result_writer #(
  parameter int IN_WIDTH          = 256,
  parameter int PS_BRAM_DATAWIDTH = 64,
  parameter int BRAM_ADDR_WIDTH   = 13,
  parameter int FIFO_DEPTH        = 4,
  parameter int COUNT_WIDTH       = 11
) (
  input  logic                       clk_fast,
  input  logic                       reset,
  input  logic                       start,
  input  logic [BRAM_ADDR_WIDTH-1:0] base_addr,
  input  logic [COUNT_WIDTH-1:0]     word_count,
  input  logic [IN_WIDTH-1:0]        in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       PS_BRAM_busy,
  output logic                       bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic [PS_BRAM_DATAWIDTH-1:0] bram_wdata,
  output logic                       active,
  output logic                       done,
  output logic                       overflow,
  output logic                       addr_err
);

  localparam int AW   = BRAM_ADDR_WIDTH;
  localparam int PW   = PS_BRAM_DATAWIDTH;
  localparam int CW   = COUNT_WIDTH;
  localparam int PTRW = $clog2(FIFO_DEPTH);

  localparam logic [PTRW:0] FULL_OCC = (PTRW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state, state_nx;
  logic [IN_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTRW-1:0]     wr_ptr, rd_ptr;
  logic [PTRW:0]       occ, occ_nx;
  logic [CW-1:0]       cnt_tgt, rcvd;
  logic [AW:0]         next_addr, ser_addr, beat_addr;
  logic [IN_WIDTH-1:0] ser_data;
  logic [PW-1:0]       beat_data;
  logic [1:0]          beat;
  logic                ser_valid, busy_q;
  logic                fifo_full, fifo_empty;
  logic                push, drop, pop, issue;
  logic                start_ok, write_ok;

  assign fifo_full  = (occ == FULL_OCC);
  assign fifo_empty = (occ == '0);
  assign start_ok   = (state == S_IDLE) && start;
  assign push  = (state == S_RUN) && in_valid && !fifo_full;
  assign drop  = (state == S_RUN) && in_valid && fifo_full;
  assign issue = (ser_valid || !fifo_empty) && !busy_q;
  assign pop   = !fifo_empty &&
                 (!ser_valid || (issue && beat == 2'd3));

  // Pick the beat on offer: FIFO head when the serializer is empty.
  always_comb begin
    if (ser_valid) begin
      beat_addr = ser_addr + (AW+1)'(beat);
      beat_data = ser_data[int'(beat)*PW +: PW];
    end else begin
      beat_addr = next_addr;
      beat_data = mem[rd_ptr][PW-1:0];
    end
  end

  assign write_ok = issue && !beat_addr[AW];

  // Next FIFO occupancy from push/pop.
  always_comb begin
    occ_nx = occ;
    if (push && !pop) occ_nx = occ + (PTRW+1)'(1);
    else if (pop && !push) occ_nx = occ - (PTRW+1)'(1);
  end

  // Frame state sequencing.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (start)
          state_nx = (word_count == '0) ? S_DONE : S_RUN;
      S_RUN:
        if (in_valid && (rcvd + CW'(1) == cnt_tgt))
          state_nx = S_FLUSH;
      S_FLUSH:
        if (fifo_empty && !ser_valid) state_nx = S_DONE;
      S_DONE:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  // FIFO storage is not reset; occupancy alone marks it empty.
  always_ff @(posedge clk_fast) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Control, FIFO pointers, serializer and registered outputs.
  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      cnt_tgt    <= '0;
      rcvd       <= '0;
      next_addr  <= '0;
      ser_addr   <= '0;
      ser_data   <= '0;
      beat       <= '0;
      ser_valid  <= 1'b0;
      busy_q     <= 1'b0;
      in_ready   <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      active     <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      state  <= state_nx;
      occ    <= occ_nx;
      busy_q <= PS_BRAM_busy;
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (start_ok) begin
        cnt_tgt   <= word_count;
        rcvd      <= '0;
        next_addr <= {1'b0, base_addr};
      end else if (pop) begin
        next_addr <= next_addr + (AW+1)'(4);
      end
      if ((state == S_RUN) && in_valid) rcvd <= rcvd + CW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PTRW'(1);
        ser_data  <= mem[rd_ptr];
        ser_addr  <= next_addr;
        ser_valid <= 1'b1;
        beat      <= (!ser_valid && issue) ? 2'd1 : 2'd0;
      end else if (ser_valid && issue) begin
        beat <= beat + 2'd1;
        if (beat == 2'd3) ser_valid <= 1'b0;
      end
      bram_we <= write_ok;
      if (write_ok) begin
        bram_addr  <= beat_addr[AW-1:0];
        bram_wdata <= beat_data;
      end
      if (start_ok) overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
      if (start_ok) addr_err <= 1'b0;
      else if (issue && beat_addr[AW]) addr_err <= 1'b1;
      done     <= (state_nx == S_DONE);
      active   <= (state_nx == S_RUN) || (state_nx == S_FLUSH);
      in_ready <= (state_nx == S_RUN) && (occ_nx != FULL_OCC);
    end
  end

endmodule
